// File: rtl/mesi_snoop_cache_if.sv
`default_nettype none
// ============================================================================
// Module   : mesi_snoop_cache_if
// Purpose  : CPU handshake, bus-master and snoop signals of one MESI cache.
//            The cache controller uses the master view. The core/bus side
//            uses the slave view.
// Revision : 1.0 - initial release
// ============================================================================
interface mesi_snoop_cache_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  // CPU side
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_hit;
  logic [DATA_W-1:0] cpu_rdata;
  // bus-master side
  logic              bus_req;
  logic              bus_gnt;
  logic [1:0]        bus_cmd;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_wb;
  logic [DATA_W-1:0] bus_wb_data;
  logic              fill_valid;
  logic [DATA_W-1:0] fill_data;
  logic              fill_shared;
  // snoop side
  logic              snp_valid;
  logic [1:0]        snp_cmd;
  logic [ADDR_W-1:0] snp_addr;
  logic              snp_hit;
  logic              snp_supply;
  logic [DATA_W-1:0] snp_data;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_hit, cpu_rdata,
    output bus_req, bus_cmd, bus_addr, bus_wb, bus_wb_data,
    input  bus_gnt, fill_valid, fill_data, fill_shared,
    input  snp_valid, snp_cmd, snp_addr,
    output snp_hit, snp_supply, snp_data
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_hit, cpu_rdata,
    input  bus_req, bus_cmd, bus_addr, bus_wb, bus_wb_data,
    output bus_gnt, fill_valid, fill_data, fill_shared,
    output snp_valid, snp_cmd, snp_addr,
    input  snp_hit, snp_supply, snp_data
  );
endinterface
`default_nettype wire

// File: rtl/mesi_snoop_cache.sv
`default_nettype none
// ============================================================================
// Module   : mesi_snoop_cache
// Purpose  : Direct-mapped private cache controller with MESI snooping.
//            A CPU FSM handles lookup, victim write-back, bus request and
//            fill. The snoop port is serviced every cycle in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module mesi_snoop_cache #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int LINES  = 4,
  parameter int IDX_W  = $clog2(LINES)
) (
  input  wire logic           clock,
  input  wire logic           reset,
  mesi_snoop_cache_if.master  cache_if
);

  localparam logic [1:0] c_ST_I = 2'd0;
  localparam logic [1:0] c_ST_S = 2'd1;
  localparam logic [1:0] c_ST_E = 2'd2;
  localparam logic [1:0] c_ST_M = 2'd3;

  localparam logic [1:0] c_CMD_NONE = 2'd0;
  localparam logic [1:0] c_CMD_RD   = 2'd1;
  localparam logic [1:0] c_CMD_WR   = 2'd2;
  localparam logic [1:0] c_CMD_INV  = 2'd3;

  typedef enum logic [2:0] {
    FSM_IDLE   = 3'd0,
    FSM_LOOKUP = 3'd1,
    FSM_WB     = 3'd2,
    FSM_BUSREQ = 3'd3,
    FSM_FILL   = 3'd4
  } fsm_t;

  fsm_t              r_fsm, w_fsm_nxt;
  logic [1:0]        r_lstate [LINES];
  logic [ADDR_W-1:0] r_tag    [LINES];
  logic [DATA_W-1:0] r_data   [LINES];

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_cmd;
  logic              r_ready;
  logic              r_hit;
  logic [DATA_W-1:0] r_rdata;

  logic [IDX_W-1:0]  w_idx, w_sidx;
  logic [1:0]        w_cur_state;
  logic              w_hit;
  logic              w_gnt_wb, w_gnt_cmd;
  logic              w_snp_hit_cur;

  logic              w_latch, w_ready_nxt, w_hit_nxt, w_rdata_ld;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic [1:0]        w_cmd_nxt;
  logic              w_line_wr;
  logic [1:0]        w_line_state;
  logic [ADDR_W-1:0] w_line_tag;
  logic [DATA_W-1:0] w_line_data;

  logic [ADDR_W-1:0] w_eff_tag;
  logic [1:0]        w_eff_state;
  logic              w_snp_upd;
  logic [1:0]        w_snp_state;

  assign w_idx         = r_addr[IDX_W-1:0];
  assign w_sidx        = cache_if.snp_addr[IDX_W-1:0];
  assign w_cur_state   = r_lstate[w_idx];
  assign w_hit         = (r_tag[w_idx] == r_addr) && (w_cur_state != c_ST_I);
  assign w_gnt_wb      = (r_fsm == FSM_WB) && cache_if.bus_gnt;
  assign w_gnt_cmd     = (r_fsm == FSM_BUSREQ) && cache_if.bus_gnt;
  // Snoop response reflects the line as it is before this edge's updates
  assign w_snp_hit_cur = cache_if.snp_valid && (r_tag[w_sidx] == cache_if.snp_addr) &&
                         (r_lstate[w_sidx] != c_ST_I);

  assign cache_if.snp_hit     = w_snp_hit_cur;
  assign cache_if.snp_supply  = w_snp_hit_cur && (r_lstate[w_sidx] == c_ST_M);
  assign cache_if.snp_data    = w_snp_hit_cur ? r_data[w_sidx] : '0;

  assign cache_if.bus_req     = (r_fsm == FSM_WB) || (r_fsm == FSM_BUSREQ);
  assign cache_if.bus_cmd     = w_gnt_cmd ? r_cmd : c_CMD_NONE;
  assign cache_if.bus_addr    = w_gnt_wb ? r_tag[w_idx] : (w_gnt_cmd ? r_addr : '0);
  assign cache_if.bus_wb      = w_gnt_wb;
  assign cache_if.bus_wb_data = w_gnt_wb ? r_data[w_idx] : '0;

  assign cache_if.cpu_ready   = r_ready;
  assign cache_if.cpu_hit     = r_hit;
  assign cache_if.cpu_rdata   = r_rdata;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_fsm <= FSM_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  // Next-state, CPU completion and line-update decisions of the CPU FSM
  always_comb begin
    w_fsm_nxt    = r_fsm;
    w_latch      = 1'b0;
    w_ready_nxt  = 1'b0;
    w_hit_nxt    = 1'b0;
    w_rdata_ld   = 1'b0;
    w_rdata_nxt  = r_data[w_idx];
    w_cmd_nxt    = r_cmd;
    w_line_wr    = 1'b0;
    w_line_state = w_cur_state;
    w_line_tag   = r_tag[w_idx];
    w_line_data  = r_data[w_idx];
    case (r_fsm)
      FSM_IDLE: begin
        if (cache_if.cpu_req) begin
          w_latch   = 1'b1;
          w_fsm_nxt = FSM_LOOKUP;
        end
      end
      FSM_LOOKUP: begin
        // A concurrent snoop may change this line, so wait for it to land
        if (!cache_if.snp_valid) begin
          if (w_hit) begin
            if (!r_we) begin
              w_ready_nxt = 1'b1;
              w_hit_nxt   = 1'b1;
              w_rdata_ld  = 1'b1;
              w_fsm_nxt   = FSM_IDLE;
            end else if (w_cur_state == c_ST_S) begin
              w_cmd_nxt = c_CMD_INV;
              w_fsm_nxt = FSM_BUSREQ;
            end else begin
              w_line_wr    = 1'b1;
              w_line_state = c_ST_M;
              w_line_data  = r_wdata;
              w_ready_nxt  = 1'b1;
              w_hit_nxt    = 1'b1;
              w_fsm_nxt    = FSM_IDLE;
            end
          end else begin
            w_cmd_nxt = r_we ? c_CMD_WR : c_CMD_RD;
            w_fsm_nxt = (w_cur_state == c_ST_M) ? FSM_WB : FSM_BUSREQ;
          end
        end
      end
      FSM_WB: begin
        if (cache_if.bus_gnt) begin
          w_line_wr    = 1'b1;
          w_line_state = c_ST_I;
          w_fsm_nxt    = FSM_BUSREQ;
        end
      end
      FSM_BUSREQ: begin
        if (cache_if.bus_gnt) begin
          if (r_cmd == c_CMD_INV) begin
            w_line_wr    = 1'b1;
            w_line_state = c_ST_M;
            w_line_data  = r_wdata;
            w_ready_nxt  = 1'b1;
            w_fsm_nxt    = FSM_IDLE;
          end else begin
            w_fsm_nxt = FSM_FILL;
          end
        end else if ((r_cmd == c_CMD_INV) && w_snp_hit_cur && (cache_if.snp_addr == r_addr) &&
                     ((cache_if.snp_cmd == c_CMD_WR) || (cache_if.snp_cmd == c_CMD_INV))) begin
          // Our shared copy is being invalidated: an upgrade is no longer enough
          w_cmd_nxt = c_CMD_WR;
        end
      end
      FSM_FILL: begin
        if (cache_if.fill_valid) begin
          w_line_wr    = 1'b1;
          w_line_tag   = r_addr;
          w_line_state = r_we ? c_ST_M : (cache_if.fill_shared ? c_ST_S : c_ST_E);
          w_line_data  = r_we ? r_wdata : cache_if.fill_data;
          w_ready_nxt  = 1'b1;
          w_rdata_ld   = !r_we;
          w_rdata_nxt  = cache_if.fill_data;
          w_fsm_nxt    = FSM_IDLE;
        end
      end
      default: w_fsm_nxt = FSM_IDLE;
    endcase
  end

  // Snoop transition, evaluated on the line as it stands after any CPU-side update
  always_comb begin
    w_eff_tag   = r_tag[w_sidx];
    w_eff_state = r_lstate[w_sidx];
    if (w_line_wr && (w_idx == w_sidx)) begin
      w_eff_tag   = w_line_tag;
      w_eff_state = w_line_state;
    end
    w_snp_upd   = 1'b0;
    w_snp_state = w_eff_state;
    if (cache_if.snp_valid && (w_eff_tag == cache_if.snp_addr) && (w_eff_state != c_ST_I)) begin
      case (cache_if.snp_cmd)
        c_CMD_RD: begin
          if ((w_eff_state == c_ST_M) || (w_eff_state == c_ST_E)) begin
            w_snp_upd   = 1'b1;
            w_snp_state = c_ST_S;
          end
        end
        c_CMD_WR: begin
          w_snp_upd   = 1'b1;
          w_snp_state = c_ST_I;
        end
        c_CMD_INV: begin
          if (w_eff_state == c_ST_S) begin
            w_snp_upd   = 1'b1;
            w_snp_state = c_ST_I;
          end
        end
        default: w_snp_upd = 1'b0;
      endcase
    end
  end

  // Line storage: CPU update first, snoop transition wins on the state field
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        r_lstate[i] <= c_ST_I;
        r_tag[i]    <= '0;
        r_data[i]   <= '0;
      end
    end else begin
      if (w_line_wr) begin
        r_lstate[w_idx] <= w_line_state;
        r_tag[w_idx]    <= w_line_tag;
        r_data[w_idx]   <= w_line_data;
      end
      if (w_snp_upd) r_lstate[w_sidx] <= w_snp_state;
    end
  end

  // Latched CPU request, pending bus command and registered CPU outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cmd   <= c_CMD_NONE;
      r_ready <= 1'b0;
      r_hit   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_latch) begin
        r_we    <= cache_if.cpu_we;
        r_addr  <= cache_if.cpu_addr;
        r_wdata <= cache_if.cpu_wdata;
      end
      r_cmd   <= w_cmd_nxt;
      r_ready <= w_ready_nxt;
      r_hit   <= w_hit_nxt;
      if (w_rdata_ld) r_rdata <= w_rdata_nxt;
    end
  end

endmodule
`default_nettype wire
